// File: rtl/dmux_1_to_n_stream_if.sv
// rtl/dmux_1_to_n_stream_if.sv - stream/control bundle between a producer and the 1-to-N demux
interface dmux_1_to_n_stream_if #(
  parameter int MXwidth = 32,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = $clog2(NUM_OUT)
);
  logic                       mode;
  logic                       ch_clear;
  logic [SEL_W-1:0]           sel;
  logic [MXwidth-1:0]         s_data;
  logic                       s_valid;
  logic                       s_ready;
  logic [NUM_OUT*MXwidth-1:0] m_data;
  logic [NUM_OUT-1:0]         m_valid;
  logic [NUM_OUT-1:0]         m_ready;
  logic [SEL_W-1:0]           cur_ch;
  logic                       wrap;
  logic                       sel_err;

  modport master (
    output mode, ch_clear, sel, s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, cur_ch, wrap, sel_err
  );

  modport slave (
    input  mode, ch_clear, sel, s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, cur_ch, wrap, sel_err
  );
endinterface

// File: rtl/dmux_1_to_n_stream.sv
// rtl/dmux_1_to_n_stream.sv - registered 1-to-N stream demux, explicit or round-robin burst routing
module dmux_1_to_n_stream #(
  parameter int MXwidth   = 32,
  parameter int NUM_OUT   = 4,
  parameter int SEL_W     = $clog2(NUM_OUT),
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  dmux_1_to_n_stream_if.slave  bus
);

  logic [NUM_OUT*MXwidth-1:0] hold_d;
  logic [NUM_OUT-1:0]         hold_v;
  logic [SEL_W-1:0]           ptr;
  logic [CNT_W-1:0]           cnt;
  logic                       wrap_r;
  logic                       sel_err_r;

  logic [SEL_W-1:0]           tgt;
  logic                       tgt_ok;
  logic [NUM_OUT-1:0]         hit;
  logic                       blocked;
  logic                       accept;

  // Target decode is done per channel so an out-of-range select never indexes past hold_v.
  always_comb begin
    tgt     = bus.mode ? ptr : bus.sel;
    tgt_ok  = (int'(tgt) < NUM_OUT);
    hit     = '0;
    blocked = 1'b0;
    for (int k = 0; k < NUM_OUT; k++) begin
      hit[k]  = (int'(tgt) == k);
      blocked = blocked | (hit[k] & hold_v[k] & ~bus.m_ready[k]);
    end
    bus.s_ready = ~bus.ch_clear & ~blocked;
    accept      = bus.s_valid & bus.s_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_d    <= '0;
      hold_v    <= '0;
      ptr       <= '0;
      cnt       <= '0;
      wrap_r    <= 1'b0;
      sel_err_r <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (accept && hit[k]) begin
          hold_d[k*MXwidth +: MXwidth] <= bus.s_data;
          hold_v[k]                    <= 1'b1;
        end else if (hold_v[k] && bus.m_ready[k]) begin
          hold_d[k*MXwidth +: MXwidth] <= '0;
          hold_v[k]                    <= 1'b0;
        end
      end
      sel_err_r <= accept & ~bus.mode & ~tgt_ok;
      wrap_r    <= 1'b0;
      // A clear outranks any advance; the pointer only moves on auto-mode accepts.
      if (bus.ch_clear) begin
        ptr <= '0;
        cnt <= '0;
      end else if (accept && bus.mode) begin
        if (cnt == CNT_W'(BURST_LEN - 1)) begin
          cnt <= '0;
          if (ptr == SEL_W'(NUM_OUT - 1)) begin
            ptr    <= '0;
            wrap_r <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign bus.m_data  = hold_d;
  assign bus.m_valid = hold_v;
  assign bus.cur_ch  = ptr;
  assign bus.wrap    = wrap_r;
  assign bus.sel_err = sel_err_r;

endmodule
